// File: rtl/issue_scoreboard_pkg.sv
// Shared core definitions for the issue scoreboard: register index width,
// opcode classes and the fence-drain FSM states.
package issue_scoreboard_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 1 << REG_IDX_W;

    typedef enum logic [2:0] {
        OP_ALU    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_STORE  = 3'd2,
        OP_BRANCH = 3'd3,
        OP_FENCE  = 3'd4
    } op_class_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } sb_state_e;

    // Stores and branches read rs2 even when the decoder flags an immediate.
    function automatic logic rs2_checked(input logic imm_type, input logic is_store,
                                         input logic is_branch);
        return !imm_type || is_store || is_branch;
    endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// ID/EX/WB handshake bundle between the decode stage and the issue scoreboard.
interface issue_scoreboard_if
    import issue_scoreboard_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) ();

    logic                 id_valid;
    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic [REG_IDX_W-1:0] id_rd;
    logic                 id_imm_type;
    logic                 id_is_load;
    logic                 id_is_store;
    logic                 id_is_branch;
    logic                 id_is_fence;
    logic                 ex_ready;
    logic                 flush;
    logic                 wb_valid;
    logic [REG_IDX_W-1:0] wb_rd;
    logic                 issue;
    logic                 stall;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic                 sb_err;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_imm_type, id_is_load, id_is_store,
               id_is_branch, id_is_fence, ex_ready, flush, wb_valid, wb_rd,
        input  issue, stall, stall_cycles, sb_err
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_imm_type, id_is_load, id_is_store,
               id_is_branch, id_is_fence, ex_ready, flush, wb_valid, wb_rd,
        output issue, stall, stall_cycles, sb_err
    );

endinterface

// File: rtl/issue_scoreboard_sb_counter.sv
// Per-register pending-load counter: saturating up/down, simultaneous
// up and down cancel out.
module sb_counter #(
    parameter int MAX_PEND = 3,
    parameter int W        = $clog2(MAX_PEND + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec && count != W'(MAX_PEND)) begin
            count <= count + 1'b1;
        end else if (dec && !inc && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: tracks in-flight loads per register, blocks RAW
// and over-subscribed WAW hazards, and drains outstanding loads before a fence.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int MAX_PEND  = 3,
    parameter int CNT_WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    issue_scoreboard_if.slave  bus
);

    localparam int CW = $clog2(MAX_PEND + 1);

    logic [NUM_REGS-1:0][CW-1:0] cnt;
    logic [NUM_REGS-1:0][CW-1:0] eff;
    logic [NUM_REGS-1:0]         wb_hit;
    logic [NUM_REGS-1:0]         eff_nz;
    logic [NUM_REGS-1:1]         zero;

    sb_state_e            state, state_next;
    logic                 any_pend, rs1_raw, rs2_raw, waw_full, hazard;
    logic                 issue_c, stall_c, load_inc, wb_err;
    logic                 sb_err;
    logic [CNT_WIDTH-1:0] stall_cnt;

    // x0 is hard-wired idle; eff folds in a same-cycle writeback so it never stalls.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        if (r == 0) begin : g_x0
            assign cnt[r]    = '0;
            assign wb_hit[r] = 1'b0;
        end else begin : g_track
            assign wb_hit[r] = bus.wb_valid && (bus.wb_rd == REG_IDX_W'(r)) && !zero[r];
            sb_counter #(
                .MAX_PEND (MAX_PEND),
                .W        (CW)
            ) u_cnt (
                .clk   (clk),
                .reset (reset),
                .inc   (load_inc && (bus.id_rd == REG_IDX_W'(r))),
                .dec   (wb_hit[r]),
                .count (cnt[r]),
                .zero  (zero[r])
            );
        end
        assign eff[r]    = cnt[r] - CW'(wb_hit[r]);
        assign eff_nz[r] = (eff[r] != '0);
    end

    assign any_pend = |eff_nz;
    assign rs1_raw  = (bus.id_rs1 != '0) && eff_nz[bus.id_rs1];
    assign rs2_raw  = rs2_checked(bus.id_imm_type, bus.id_is_store, bus.id_is_branch)
                      && (bus.id_rs2 != '0) && eff_nz[bus.id_rs2];
    assign waw_full = bus.id_is_load && (bus.id_rd != '0) && (eff[bus.id_rd] == CW'(MAX_PEND));
    assign hazard   = bus.id_valid && (rs1_raw || rs2_raw || waw_full);

    assign issue_c  = !reset && bus.id_valid && !bus.flush && bus.ex_ready && !hazard
                      && (state == ST_RUN) && !(bus.id_is_fence && any_pend);
    assign stall_c  = !reset && bus.id_valid && !bus.flush && !issue_c;
    assign load_inc = issue_c && bus.id_is_load && (bus.id_rd != '0);
    assign wb_err   = bus.wb_valid && (bus.wb_rd != '0) && (cnt[bus.wb_rd] == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:   if (bus.id_valid && bus.id_is_fence && !bus.flush && any_pend)
                          state_next = ST_DRAIN;
            ST_DRAIN: if (bus.flush || !any_pend)
                          state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_err    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (wb_err) begin
                sb_err <= 1'b1;
            end
            if (stall_c && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign bus.issue        = issue_c;
    assign bus.stall        = stall_c;
    assign bus.stall_cycles = stall_cnt;
    assign bus.sb_err       = sb_err;

endmodule
